dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester controller sharing the single-port, byte-addressed, big-endian 16-bit Data_Memory.
- Requester A is the CPU load/store path. Requester B is the loader/debug DMA port.
- Serialises accesses with round-robin arbitration and rejects misaligned addresses.
- Drives the memory's address, write data, Mem_Write and Mem_Read, and returns registered read data with a completion pulse.

Parameters:
AW, 8, requester byte-address width (memory depth 2^AW bytes)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
a_req  in  1  requester A access request
a_we  in  1  A: 1 = write, 0 = read
a_addr  in  AW  A byte address (must be even)
a_wdata  in  16  A write data
a_gnt  out  1  A request accepted (1-cycle pulse)
a_rvalid  out  1  A access complete (1-cycle pulse)
a_err  out  1  A misaligned error, valid with a_rvalid
a_rdata  out  16  A read data, valid with a_rvalid
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_err, b_rdata  same as A, for requester B
mem_addr  out  16  to memory address input, zero-extended latched address
mem_wdata  out  16  to memory write-data input
mem_write  out  1  to Mem_Write
mem_read  out  1  to Mem_Read
mem_rdata  in  16  from memory read output

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset: state=IDLE; last_served=B, so A wins the first tie. All outputs 0. Latched address, data, we and owner are cleared.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Throughput is one access per 3 cycles.
- IDLE, cycle N: req sampled only here.
  - If no req: stay in IDLE.
  - If exactly one req: that requester wins.
  - If both req: the requester not equal to last_served wins.
  - On a win: latch owner, we, addr, wdata and err = addr[0]. Update last_served. Go to ACCESS.
- ACCESS, cycle N+1: owner's gnt=1 for this cycle only.
  - If err=0: mem_addr = latched addr, mem_wdata = latched wdata, mem_write = we, mem_read = ~we.
  - The memory commits the write on the falling edge within this cycle.
  - If err=0 and read: register mem_rdata at the rising edge ending N+1.
  - If err=1: all mem_* outputs stay 0. No memory access occurs.
  - Next state is RESP.
- RESP, cycle N+2: owner's rvalid=1 and err = latched err.
  - rdata = captured data for an error-free read, otherwise 0.
  - Non-owner rvalid/err stay 0.
  - Next state is IDLE. The next grant is no earlier than N+4.
- rdata holds its value until that requester's next rvalid. Only rvalid/gnt/err are pulses.
- mem_* outputs are 0 in every state except error-free ACCESS. mem_read and mem_write are never both 1.
- Requester protocol:
  - Hold req and its fields stable until gnt.
  - Drop req in the gnt cycle or later. req seen again in IDLE is treated as a new request.
  - Field changes after acceptance are ignored.
- Address rules:
  - Word access uses byte addr (big-endian high byte) and addr+1.
  - Even-only addressing means addr+1 never wraps past 2^AW-1.
  - Max legal address is 2^AW-2.
- Round-robin fairness: under continuous requests from both sides, grants alternate A, B, A, B.
- Reset mid-operation:
  - Reset in ACCESS or RESP aborts the transaction. No rvalid is issued.
  - mem_* outputs are 0 from the cycle after reset is sampled.
  - A write strobe already presented in ACCESS may have committed.

Test Plan:
- Reset then A write 0xBEEF @0x10, then A read @0x10: a_gnt at N+1, mem_write=1 for 1 cycle, a_rvalid at N+2 with a_err=0; read returns a_rdata=0xBEEF.
- B read of the same 0x10 after the A write: b_rdata=0xBEEF. Byte check via write 0x1234 @0x20 then read @0x20: 0x1234, confirming byte 0x20=0x12 and 0x21=0x34.
- A and B assert req in the same cycle, both held ~10 cycles: grant order A, B, A, B. Each rvalid goes to the correct owner only. Grants are at least 3 cycles apart.
- A write @0x11 (odd): a_gnt then a_rvalid with a_err=1, a_rdata=0. mem_write stays 0 throughout. A read @0x10 still returns its old value.
- Reset asserted during ACCESS of a B read: no b_rvalid. All outputs 0 the next cycle. After reset, a simultaneous A/B request grants A first.
- Boundary: A write 0xA5C3 @0xFE, then read @0xFE: 0xA5C3. mem_addr=0x00FE during ACCESS.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Purpose: bundles the two requester channels and the Data_Memory bus of dmem_arbiter.
// Latency: none, wires only.
// Backpressure: requester A/B hold req until gnt; the memory side has no backpressure.
// Ports/signals:
//   a_*/b_*  : req, we, addr, wdata in; gnt, rvalid, err, rdata out (arbiter view)
//   mem_*    : addr, wdata, write, read out; rdata in (arbiter view)
// Modports: slave = arbiter side, master = requesters + memory side.
interface dmem_arbiter_if #(
  parameter int AW = 8
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [15:0]   a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic          a_err;
  logic [15:0]   a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [15:0]   b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic          b_err;
  logic [15:0]   b_rdata;

  logic [15:0]   mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_write;
  logic          mem_read;
  logic [15:0]   mem_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_err, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_err, b_rdata,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_err, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_err, b_rdata,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose: round-robin arbiter serialising requesters A (CPU) and B (DMA) onto a 16-bit big-endian Data_Memory.
// Latency: request sampled in IDLE (N), gnt + memory strobe at N+1, rvalid/err/rdata at N+2; one access per 3 cycles.
// Backpressure: requesters hold req and fields until gnt; losers simply keep waiting in IDLE.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : dmem_arbiter_if.slave carrying both requester channels and the memory bus
module dmem_arbiter #(
  parameter int AW = 8
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic          r_last_b;   // 1: B was served last, so A wins the next tie
  logic          r_owner_b;  // owner of the in-flight access
  logic          r_we;
  logic          r_err;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_wdata;
  logic [15:0]   r_a_rdata;
  logic [15:0]   r_b_rdata;

  logic          w_win_a;
  logic          w_win_b;
  logic          w_accept;
  logic [15:0]   w_resp_data;

  logic          w_a_gnt;
  logic          w_b_gnt;
  logic          w_a_rvalid;
  logic          w_b_rvalid;
  logic          w_a_err;
  logic          w_b_err;
  logic [15:0]   w_mem_addr;
  logic [15:0]   w_mem_wdata;
  logic          w_mem_write;
  logic          w_mem_read;

  // On a tie the side that was not served last wins.
  assign w_win_a  = bus.a_req & (~bus.b_req | r_last_b);
  assign w_win_b  = bus.b_req & (~bus.a_req | ~r_last_b);
  assign w_accept = (r_state == ST_IDLE) & (w_win_a | w_win_b);

  // Errored accesses and writes return zero; only a clean read returns memory data.
  assign w_resp_data = (!r_err && !r_we) ? bus.mem_rdata : 16'h0000;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_win_a | w_win_b) w_next_state = ST_ACCESS;
      ST_ACCESS: w_next_state = ST_RESP;
      ST_RESP:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Request latch and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_b  <= 1'b1;
      r_owner_b <= 1'b0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 16'h0000;
      r_a_rdata <= 16'h0000;
      r_b_rdata <= 16'h0000;
    end else begin
      if (w_accept) begin
        r_owner_b <= w_win_b;
        r_last_b  <= w_win_b;
        r_we      <= w_win_b ? bus.b_we    : bus.a_we;
        r_addr    <= w_win_b ? bus.b_addr  : bus.a_addr;
        r_wdata   <= w_win_b ? bus.b_wdata : bus.a_wdata;
        r_err     <= w_win_b ? bus.b_addr[0] : bus.a_addr[0];
      end
      // Memory output is sampled at the edge closing ACCESS, so the owner's
      // rdata is already stable in the RESP cycle and holds until its next rvalid.
      if (r_state == ST_ACCESS) begin
        if (r_owner_b) begin
          r_b_rdata <= w_resp_data;
        end else begin
          r_a_rdata <= w_resp_data;
        end
      end
    end
  end

  // Output logic
  always_comb begin
    w_a_gnt     = 1'b0;
    w_b_gnt     = 1'b0;
    w_a_rvalid  = 1'b0;
    w_b_rvalid  = 1'b0;
    w_a_err     = 1'b0;
    w_b_err     = 1'b0;
    w_mem_addr  = 16'h0000;
    w_mem_wdata = 16'h0000;
    w_mem_write = 1'b0;
    w_mem_read  = 1'b0;
    case (r_state)
      ST_ACCESS: begin
        w_a_gnt = ~r_owner_b;
        w_b_gnt = r_owner_b;
        // A misaligned access never touches the memory.
        if (!r_err) begin
          w_mem_addr  = {{(16-AW){1'b0}}, r_addr};
          w_mem_wdata = r_wdata;
          w_mem_write = r_we;
          w_mem_read  = ~r_we;
        end
      end
      ST_RESP: begin
        w_a_rvalid = ~r_owner_b;
        w_b_rvalid = r_owner_b;
        w_a_err    = ~r_owner_b & r_err;
        w_b_err    = r_owner_b & r_err;
      end
      default: ;
    endcase
  end

  assign bus.a_gnt     = w_a_gnt;
  assign bus.b_gnt     = w_b_gnt;
  assign bus.a_rvalid  = w_a_rvalid;
  assign bus.b_rvalid  = w_b_rvalid;
  assign bus.a_err     = w_a_err;
  assign bus.b_err     = w_b_err;
  assign bus.a_rdata   = r_a_rdata;
  assign bus.b_rdata   = r_b_rdata;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.mem_write = w_mem_write;
  assign bus.mem_read  = w_mem_read;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: self-checking bench for dmem_arbiter with a big-endian byte memory model and response scoreboard.
// Latency: expects gnt one cycle after req is sampled and rvalid one cycle after gnt.
// Backpressure: requesters hold req until gnt, then drop it.
module tb_dmem_arbiter;

  logic clk;
  logic reset;

  dmem_arbiter_if #(.AW(8)) bus ();

  dmem_arbiter #(.AW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- memory model (bench-owned Data_Memory) ----------------
  logic [7:0] sim_mem [256];
  logic [7:0] ref_mem [256];
  logic       mem_init_done = 1'b0;
  logic [7:0] m_lo;
  logic [7:0] m_hi;

  assign m_hi = bus.mem_addr[7:0];
  assign m_lo = bus.mem_addr[7:0] + 8'd1;
  assign bus.mem_rdata = {sim_mem[m_hi], sim_mem[m_lo]};

  // Writes commit on the falling edge inside the ACCESS cycle.
  always @(negedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) sim_mem[i] <= 8'(i);
      mem_init_done <= 1'b1;
    end else if (bus.mem_write) begin
      sim_mem[m_hi] <= bus.mem_wdata[15:8];
      sim_mem[m_lo] <= bus.mem_wdata[7:0];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_b;
    bit          err;
    logic [15:0] rdata;
  } exp_t;

  exp_t q[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.mem_write || bus.mem_read) begin
      n_cmp++;
      if ((bus.mem_write && bus.mem_read) || !(bus.a_gnt || bus.b_gnt)) begin
        n_fail++;
        $display("FAIL mem_strobe: write=%0b read=%0b gnt_a=%0b gnt_b=%0b, required single strobe only in a grant cycle",
                 bus.mem_write, bus.mem_read, bus.a_gnt, bus.b_gnt);
      end
    end
    if (bus.a_rvalid || bus.b_rvalid) begin
      n_cmp++;
      if (bus.a_rvalid && bus.b_rvalid) begin
        n_fail++;
        $display("FAIL rvalid_both: a_rvalid=1 b_rvalid=1, required at most one");
      end else if (q.size() == 0) begin
        n_fail++;
        $display("FAIL rvalid_unexpected: a_rvalid=%0b b_rvalid=%0b, required none", bus.a_rvalid, bus.b_rvalid);
      end else begin
        e = q.pop_front();
        if (bus.b_rvalid !== e.is_b) begin
          n_fail++;
          $display("FAIL resp_owner: got b=%0b, required b=%0b", bus.b_rvalid, e.is_b);
        end else if (e.is_b && ({bus.b_err, bus.a_err, bus.b_rdata} !== {e.err, 1'b0, e.rdata})) begin
          n_fail++;
          $display("FAIL resp_b: err=%0b a_err=%0b rdata=%h, required err=%0b a_err=0 rdata=%h",
                   bus.b_err, bus.a_err, bus.b_rdata, e.err, e.rdata);
        end else if (!e.is_b && ({bus.a_err, bus.b_err, bus.a_rdata} !== {e.err, 1'b0, e.rdata})) begin
          n_fail++;
          $display("FAIL resp_a: err=%0b b_err=%0b rdata=%h, required err=%0b b_err=0 rdata=%h",
                   bus.a_err, bus.b_err, bus.a_rdata, e.err, e.rdata);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic exp_t predict(input bit is_b, input bit we, input logic [7:0] addr, input logic [15:0] wdata);
    exp_t e;
    logic [7:0] a1;
    a1      = addr + 8'd1;
    e.is_b  = is_b;
    e.err   = addr[0];
    e.rdata = (!addr[0] && !we) ? {ref_mem[addr], ref_mem[a1]} : 16'h0000;
    if (!addr[0] && we) begin
      ref_mem[addr] = wdata[15:8];
      ref_mem[a1]   = wdata[7:0];
    end
    return e;
  endfunction

  task automatic drive_req(input bit is_b, input bit req, input bit we, input logic [7:0] addr, input logic [15:0] wdata);
    if (is_b) begin
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end else begin
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end
  endtask

  // Single access from an idle arbiter; called at posedge+1.
  task automatic issue(input bit is_b, input bit we, input logic [7:0] addr, input logic [15:0] wdata);
    int n;
    bit seen;
    bit err;
    logic [34:0] mem_got;
    logic [34:0] mem_exp;
    err = addr[0];
    q.push_back(predict(is_b, we, addr, wdata));
    drive_req(is_b, 1'b1, we, addr, wdata);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = is_b ? bus.b_gnt : bus.a_gnt;
    end
    drive_req(is_b, 1'b0, 1'b0, 8'h00, 16'h0000);
    n_cmp++;
    if (!seen || n != 2) begin
      n_fail++;
      $display("FAIL gnt_latency: seen=%0b after %0d negedges, required grant on negedge 2", seen, n);
    end
    mem_got = {bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata};
    mem_exp = err ? 35'd0 : {we, ~we, 8'h00, addr, we ? wdata : wdata};
    n_cmp++;
    if (mem_got !== mem_exp) begin
      n_fail++;
      $display("FAIL mem_bus: w=%0b r=%0b addr=%h wdata=%h, required w=%0b r=%0b addr=%h wdata=%h",
               mem_got[34], mem_got[33], mem_got[31:16], mem_got[15:0],
               mem_exp[34], mem_exp[33], mem_exp[31:16], mem_exp[15:0]);
    end
    @(negedge clk);
    n_cmp++;
    if ((is_b ? bus.b_rvalid : bus.a_rvalid) !== 1'b1) begin
      n_fail++;
      $display("FAIL rvalid_latency: rvalid=%0b one cycle after grant, required 1", is_b ? bus.b_rvalid : bus.a_rvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.a_gnt, bus.a_rvalid, bus.a_err, bus.a_rdata} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_a: gnt=%0b rvalid=%0b err=%0b rdata=%h, required all 0", bus.a_gnt, bus.a_rvalid, bus.a_err, bus.a_rdata);
    end
    n_cmp++;
    if ({bus.b_gnt, bus.b_rvalid, bus.b_err, bus.b_rdata} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_b: gnt=%0b rvalid=%0b err=%0b rdata=%h, required all 0", bus.b_gnt, bus.b_rvalid, bus.b_err, bus.b_rdata);
    end
    n_cmp++;
    if ({bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_mem: w=%0b r=%0b addr=%h wdata=%h, required all 0", bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Both sides request continuously; A must win first straight out of reset.
  task automatic test_round_robin();
    bit [3:0] order;
    int k;
    int last_c;
    order  = 4'b1010;  // k=0..3 -> A, B, A, B
    k      = 0;
    last_c = 0;
    for (int i = 0; i < 4; i++) q.push_back(predict(order[i], 1'b0, order[i] ? 8'h20 : 8'h10, 16'h0000));
    drive_req(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
    drive_req(1'b1, 1'b1, 1'b0, 8'h20, 16'h0000);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.a_gnt || bus.b_gnt) begin
        n_cmp++;
        if (k >= 4 || bus.a_gnt == bus.b_gnt || bus.b_gnt != order[k]) begin
          n_fail++;
          $display("FAIL rr_order: grant #%0d a=%0b b=%0b, required b=%0b", k, bus.a_gnt, bus.b_gnt, (k < 4) ? order[k] : 1'b0);
        end
        if (k > 0) begin
          n_cmp++;
          if (c - last_c != 3) begin
            n_fail++;
            $display("FAIL rr_spacing: grants %0d cycles apart, required 3", c - last_c);
          end
        end
        last_c = c;
        k++;
      end
    end
    drive_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    n_cmp++;
    if (k != 4) begin
      n_fail++;
      $display("FAIL rr_count: %0d grants, required 4", k);
    end
    drain();
  endtask

  task automatic test_write_read();
    issue(1'b0, 1'b1, 8'h10, 16'hBEEF);
    issue(1'b0, 1'b0, 8'h10, 16'h0000);
    n_cmp++;
    if (bus.a_rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL a_read_beef: a_rdata=%h, required beef", bus.a_rdata);
    end
  endtask

  task automatic test_bytes();
    issue(1'b1, 1'b0, 8'h10, 16'h0000);
    n_cmp++;
    if ({bus.b_rdata, bus.a_rdata} !== {16'hBEEF, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL b_read_hold: b_rdata=%h a_rdata=%h, required beef beef", bus.b_rdata, bus.a_rdata);
    end
    issue(1'b0, 1'b1, 8'h20, 16'h1234);
    issue(1'b1, 1'b0, 8'h20, 16'h0000);
    n_cmp++;
    if ({sim_mem[8'h20], sim_mem[8'h21], bus.b_rdata} !== {8'h12, 8'h34, 16'h1234}) begin
      n_fail++;
      $display("FAIL byte_order: m20=%h m21=%h b_rdata=%h, required 12 34 1234", sim_mem[8'h20], sim_mem[8'h21], bus.b_rdata);
    end
  endtask

  task automatic test_misaligned();
    issue(1'b0, 1'b1, 8'h11, 16'hFFFF);
    n_cmp++;
    if (bus.a_rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL misaligned_rdata: a_rdata=%h, required 0000", bus.a_rdata);
    end
    issue(1'b0, 1'b0, 8'h10, 16'h0000);
    n_cmp++;
    if (bus.a_rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL misaligned_intact: a_rdata=%h, required beef", bus.a_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen;
    drive_req(1'b1, 1'b1, 1'b0, 8'h20, 16'h0000);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = bus.b_gnt;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL abort_gnt: no b_gnt within %0d cycles, required one", n);
    end
    reset = 1'b1;
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    n_cmp++;
    if ({bus.a_gnt, bus.a_rvalid, bus.a_err, bus.a_rdata, bus.b_gnt, bus.b_rvalid, bus.b_err, bus.b_rdata,
         bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata} !== 72'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: b_rvalid=%0b b_gnt=%0b mem_w=%0b mem_r=%0b mem_addr=%h a_rdata=%h b_rdata=%h, required all 0",
               bus.b_rvalid, bus.b_gnt, bus.mem_write, bus.mem_read, bus.mem_addr, bus.a_rdata, bus.b_rdata);
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (bus.b_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_rvalid: b_rvalid=%0b after reset, required 0", bus.b_rvalid);
      end
    end
    @(posedge clk); #1;
    q.push_back(predict(1'b0, 1'b0, 8'h10, 16'h0000));
    q.push_back(predict(1'b1, 1'b0, 8'h20, 16'h0000));
    drive_req(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
    drive_req(1'b1, 1'b1, 1'b0, 8'h20, 16'h0000);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = bus.a_gnt | bus.b_gnt;
    end
    n_cmp++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_reset_first: a_gnt=%0b b_gnt=%0b, required a_gnt=1 b_gnt=0", bus.a_gnt, bus.b_gnt);
    end
    drive_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = bus.b_gnt;
    end
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL post_reset_b: no b_gnt within %0d cycles, required one", n);
    end
    drain();
  endtask

  task automatic test_boundary();
    issue(1'b0, 1'b1, 8'hFE, 16'hA5C3);
    issue(1'b0, 1'b0, 8'hFE, 16'h0000);
    n_cmp++;
    if (bus.a_rdata !== 16'hA5C3) begin
      n_fail++;
      $display("FAIL boundary_read: a_rdata=%h, required a5c3", bus.a_rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
    test_reset();
    test_round_robin();
    test_write_read();
    test_bytes();
    test_misaligned();
    test_reset_mid();
    test_boundary();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
